// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Radix-2: one product or quotient bit per CALC cycle. Signed operations work
// on magnitudes during CALC and apply the result sign in FIX.
module muldiv_unit #(
    parameter int unsigned ITER = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    input  logic        cancel,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned      CNT_W     = $clog2(ITER) + 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITER - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             is_div_q;   // operation is DIV/DIVU
    logic             dz_q;       // divide by zero
    logic             neg_q;      // negate product / quotient in FIX
    logic             rneg_q;     // negate remainder in FIX
    logic [31:0]      rs_q;       // raw dividend, returned in HI on divide by zero
    logic [31:0]      b_q;        // multiplicand or divisor magnitude
    logic [63:0]      work_q;     // {acc/remainder, multiplier/quotient}
    logic [63:0]      work_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;

    logic             accept;
    logic             last_iter;
    logic             op_signed;
    logic             op_div;
    logic [31:0]      rs_mag;
    logic [31:0]      rt_mag;
    logic [32:0]      mul_sum;
    logic [32:0]      div_top;
    logic [31:0]      div_diff;
    logic             div_ge;
    logic [63:0]      prod_fix;

    assign accept    = ((state_q == IDLE) || (state_q == DONE)) && start && !cancel;
    assign last_iter = (cnt_q == LAST_ITER);
    assign op_signed = ~op[0];
    assign op_div    = op[1];
    assign rs_mag    = (op_signed && rs[31]) ? -rs : rs;
    assign rt_mag    = (op_signed && rt[31]) ? -rt : rt;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; cancel beats start in every state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = CALC;
            CALC: begin
                if (cancel)         state_d = IDLE;
                else if (last_iter) state_d = FIX;
            end
            FIX:     state_d = cancel ? IDLE : DONE;
            DONE:    state_d = accept ? CALC : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Status outputs decoded from state
    always_comb begin
        busy = (state_q == CALC) || (state_q == FIX);
        done = (state_q == DONE);
    end

    // One iteration: shift-add multiply step or restoring divide step
    always_comb begin
        mul_sum  = {1'b0, work_q[63:32]} + (work_q[0] ? {1'b0, b_q} : 33'd0);
        div_top  = work_q[63:31];
        div_ge   = (div_top >= {1'b0, b_q});
        div_diff = div_top[31:0] - b_q;
        if (is_div_q) begin
            work_d = {(div_ge ? div_diff : div_top[31:0]), work_q[30:0], div_ge};
        end else begin
            work_d = {mul_sum, work_q[31:1]};
        end
    end

    // Sign correction and HI/LO commit on the FIX -> DONE edge
    always_comb begin
        hi_d     = hi_q;
        lo_d     = lo_q;
        prod_fix = neg_q ? -work_q : work_q;
        if ((state_q == FIX) && !cancel) begin
            if (dz_q) begin
                hi_d = rs_q;
                lo_d = '1;
            end else if (is_div_q) begin
                lo_d = neg_q  ? -work_q[31:0]  : work_q[31:0];
                hi_d = rneg_q ? -work_q[63:32] : work_q[63:32];
            end else begin
                {hi_d, lo_d} = prod_fix;
            end
        end
    end

    // Operand latch, iteration datapath and architectural registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            dz_q     <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            rs_q     <= '0;
            b_q      <= '0;
            work_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
            if (accept) begin
                cnt_q    <= '0;
                is_div_q <= op_div;
                dz_q     <= op_div && (rt == 32'd0);
                neg_q    <= op_signed && (rs[31] ^ rt[31]);
                rneg_q   <= op_signed && op_div && rs[31];
                rs_q     <= rs;
                if (op_div) begin
                    b_q    <= rt_mag;
                    work_q <= {32'd0, rs_mag};
                end else begin
                    b_q    <= rs_mag;
                    work_q <= {32'd0, rt_mag};
                end
            end else if ((state_q == CALC) && !cancel) begin
                work_q <= work_d;
                cnt_q  <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: expected HI/LO pushed to a scoreboard
// queue at issue time, popped and compared when done pulses.
module tb_muldiv_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        cancel = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] rs = '0;
    logic [31:0] rt = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int          errors = 0;
    int          checks = 0;
    logic [63:0] exp_q[$];
    logic [31:0] last_hi = '0;
    logic [31:0] last_lo = '0;

    typedef struct packed {
        logic [1:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] e;
    } vec_t;
    vec_t vecs[11];

    muldiv_unit #(.ITER(32)) dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .op    (op),
        .rs    (rs),
        .rt    (rt),
        .cancel(cancel),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, got no summary, want completion");
        $fatal(1);
    end

    // Reference model: {hi, lo}
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] x, y, p;
        int sa, sb, q, r;
        case (o)
            2'd0: begin
                x = {{32{a[31]}}, a};
                y = {{32{b[31]}}, b};
                p = x * y;
                return p;
            end
            2'd1: return {32'd0, a} * {32'd0, b};
            2'd2: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                sa = a;
                sb = b;
                q = sa / sb;
                r = sa % sb;
                return {r, q};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // Drive one start at the next edge (called #1 after an edge); scramble inputs afterwards
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input logic [63:0] e);
        op = o;
        rs = a;
        rt = b;
        start = 1'b1;
        exp_q.push_back(e);
        @(posedge clock); #1;
        start = 1'b0;
        op = 2'($urandom);
        rs = $urandom;
        rt = $urandom;
    endtask

    // Observe from cycle 1 until done; optionally pulse start with junk operands at cycle poke
    task automatic collect(input int poke, output int dcyc, output int bcnt,
                           output logic [31:0] pre_h, output logic [31:0] pre_l,
                           output logic [31:0] h, output logic [31:0] l);
        int cyc = 1;
        dcyc = -1; bcnt = 0;
        pre_h = '0; pre_l = '0; h = '0; l = '0;
        while (cyc <= 60) begin
            if (cyc == 33) begin
                pre_h = hi;
                pre_l = lo;
            end
            if (done === 1'b1) begin
                dcyc = cyc;
                h = hi;
                l = lo;
                break;
            end
            if (busy === 1'b1) bcnt++;
            if (poke != 0 && cyc == poke) begin
                start = 1'b1;
                op = 2'($urandom);
                rs = $urandom;
                rt = $urandom;
            end else begin
                start = 1'b0;
            end
            @(posedge clock); #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        start = 1'b1; op = 2'd1; rs = '1; rt = '1;
        #2;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi: got %h want 0", hi); end
        checks++; if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo: got %h want 0", lo); end
        repeat (3) @(posedge clock);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_start_ignored: busy %b want 0", busy); end
        start = 1'b0;
        #2 reset = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_arith();
        int dcyc, bcnt;
        logic [31:0] ph, pl, h, l;
        logic [63:0] e;
        vecs[0]  = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
        vecs[1]  = '{2'd0, 32'hFFFF_FFFD, 32'h0000_0007, 64'hFFFF_FFFF_FFFF_FFEB};
        vecs[2]  = '{2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFD};
        vecs[3]  = '{2'd3, 32'd100,       32'd7,         {32'd2, 32'd14}};
        vecs[4]  = '{2'd3, 32'h1234_5678, 32'h0000_0000, 64'h1234_5678_FFFF_FFFF};
        vecs[5]  = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000};
        vecs[6]  = '{2'd2, 32'hFFFF_FF00, 32'h0000_0000, 64'hFFFF_FF00_FFFF_FFFF};
        vecs[7]  = '{2'd0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
        vecs[8]  = '{2'd2, 32'h0000_0007, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD};
        vecs[9]  = '{2'd0, 32'h0000_0007, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF9};
        vecs[10] = '{2'd1, 32'h0000_0000, 32'hDEAD_BEEF, 64'h0000_0000_0000_0000};
        for (int i = 0; i < 11; i++) begin
            issue(vecs[i].o, vecs[i].a, vecs[i].b, vecs[i].e);
            collect(0, dcyc, bcnt, ph, pl, h, l);
            e = exp_q.pop_front();
            checks++; if (dcyc != 34) begin errors++; $display("FAIL arith%0d_latency: done at cycle %0d want 34", i, dcyc); end
            checks++; if (bcnt != 33) begin errors++; $display("FAIL arith%0d_busy: busy cycles %0d want 33", i, bcnt); end
            checks++; if ({ph, pl} !== {last_hi, last_lo}) begin errors++; $display("FAIL arith%0d_hold: hi/lo before commit %h want %h", i, {ph, pl}, {last_hi, last_lo}); end
            checks++; if ({h, l} !== e) begin errors++; $display("FAIL arith%0d_result: hi/lo %h want %h", i, {h, l}, e); end
            last_hi = e[63:32];
            last_lo = e[31:0];
            @(posedge clock); #1;
            checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL arith%0d_exit: done %b busy %b want 0 0", i, done, busy); end
        end
    endtask

    task automatic test_start_while_busy();
        int dcyc, bcnt;
        logic [31:0] ph, pl, h, l;
        logic [63:0] e;
        issue(2'd1, 32'd5, 32'd6, {32'd0, 32'd30});
        collect(10, dcyc, bcnt, ph, pl, h, l);
        e = exp_q.pop_front();
        checks++; if (dcyc != 34) begin errors++; $display("FAIL busy_start_latency: done at cycle %0d want 34", dcyc); end
        checks++; if ({h, l} !== e) begin errors++; $display("FAIL busy_start_result: hi/lo %h want %h", {h, l}, e); end
        last_hi = e[63:32];
        last_lo = e[31:0];
        @(posedge clock); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_start_queued: busy %b want 0", busy); end
    endtask

    task automatic test_random();
        int dcyc, bcnt;
        logic [31:0] ph, pl, h, l, a, b;
        logic [1:0] o;
        logic [63:0] e;
        for (int i = 0; i < 8; i++) begin
            o = 2'($urandom);
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'd0 : (($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 300)) : $urandom);
            issue(o, a, b, model(o, a, b));
            collect(0, dcyc, bcnt, ph, pl, h, l);
            e = exp_q.pop_front();
            checks++; if (dcyc != 34) begin errors++; $display("FAIL rand%0d_latency: done at cycle %0d want 34", i, dcyc); end
            checks++; if ({h, l} !== e) begin errors++; $display("FAIL rand%0d_result op=%0d rs=%h rt=%h: hi/lo %h want %h", i, o, a, b, {h, l}, e); end
            last_hi = e[63:32];
            last_lo = e[31:0];
            @(posedge clock); #1;
        end
    endtask

    task automatic test_cancel();
        int bad = 0;
        int bad2 = 0;
        op = 2'd1; rs = 32'd5; rt = 32'd6; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (busy !== 1'b1 || done !== 1'b0) bad++;
            start = (c == 10);
            if (c == 10) begin rs = 32'd7; rt = 32'd9; end
            if (c == 20) cancel = 1'b1;
            @(posedge clock); #1;
        end
        cancel = 1'b0;
        start = 1'b0;
        checks++; if (bad != 0) begin errors++; $display("FAIL cancel_busy_phase: %0d bad cycles want 0", bad); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cancel_busy: busy %b in cycle 21 want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL cancel_done: done %b in cycle 21 want 0", done); end
        for (int c = 0; c < 40; c++) begin
            if (done !== 1'b0 || busy !== 1'b0) bad2++;
            @(posedge clock); #1;
        end
        checks++; if (bad2 != 0) begin errors++; $display("FAIL cancel_quiet: %0d cycles with done/busy want 0", bad2); end
        checks++; if ({hi, lo} !== {last_hi, last_lo}) begin errors++; $display("FAIL cancel_hold: hi/lo %h want %h", {hi, lo}, {last_hi, last_lo}); end
    endtask

    task automatic test_cancel_priority();
        int dcyc, bcnt;
        int bad = 0;
        logic [31:0] ph, pl, h, l;
        logic [63:0] e;
        issue(2'd3, 32'd1003, 32'd10, {32'd3, 32'd100});
        collect(0, dcyc, bcnt, ph, pl, h, l);
        e = exp_q.pop_front();
        checks++; if ({h, l} !== e) begin errors++; $display("FAIL prio_result: hi/lo %h want %h", {h, l}, e); end
        last_hi = e[63:32];
        last_lo = e[31:0];
        start = 1'b1; cancel = 1'b1; op = 2'd1; rs = 32'd3; rt = 32'd3;
        @(posedge clock); #1;
        start = 1'b0; cancel = 1'b0;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL prio_exit: busy %b done %b want 0 0", busy, done); end
        checks++; if ({hi, lo} !== {last_hi, last_lo}) begin errors++; $display("FAIL prio_hold: hi/lo %h want %h", {hi, lo}, {last_hi, last_lo}); end
        cancel = 1'b1;
        for (int c = 0; c < 36; c++) begin
            if (c == 1) cancel = 1'b0;
            if (busy !== 1'b0 || done !== 1'b0) bad++;
            @(posedge clock); #1;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL prio_idle: %0d cycles with busy/done want 0", bad); end
        checks++; if ({hi, lo} !== {last_hi, last_lo}) begin errors++; $display("FAIL prio_idle_hold: hi/lo %h want %h", {hi, lo}, {last_hi, last_lo}); end
    endtask

    task automatic test_async_reset_b2b();
        int dcyc, bcnt;
        int bad = 0;
        logic [31:0] ph, pl, h, l;
        logic [63:0] e;
        op = 2'd2; rs = 32'hFFFF_FF9C; rt = 32'd7; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (14) begin @(posedge clock); #1; end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL areset_pre: busy %b in cycle 15 want 1", busy); end
        #3 reset = 1'b1;
        start = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL areset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL areset_done: got %b want 0", done); end
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL areset_hi: got %h want 0", hi); end
        checks++; if (lo !== 32'd0) begin errors++; $display("FAIL areset_lo: got %h want 0", lo); end
        repeat (2) @(posedge clock);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL areset_start_ignored: busy %b want 0", busy); end
        start = 1'b0;
        #2 reset = 1'b0;
        last_hi = '0;
        last_lo = '0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clock); #1;
            if (busy !== 1'b0 || done !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL areset_discard: %0d cycles with busy/done want 0", bad); end

        issue(2'd1, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000);
        collect(0, dcyc, bcnt, ph, pl, h, l);
        e = exp_q.pop_front();
        checks++; if (dcyc != 34) begin errors++; $display("FAIL b2b_first_latency: done at cycle %0d want 34", dcyc); end
        checks++; if ({h, l} !== e) begin errors++; $display("FAIL b2b_first_result: hi/lo %h want %h", {h, l}, e); end
        issue(2'd2, 32'hFFFF_FF9C, 32'd7, 64'hFFFF_FFFE_FFFF_FFF2);
        collect(0, dcyc, bcnt, ph, pl, h, l);
        e = exp_q.pop_front();
        checks++; if (dcyc != 34) begin errors++; $display("FAIL b2b_second_latency: done at cycle %0d want 34", dcyc); end
        checks++; if (bcnt != 33) begin errors++; $display("FAIL b2b_second_busy: busy cycles %0d want 33", bcnt); end
        checks++; if ({ph, pl} !== 64'h0000_0001_0000_0000) begin errors++; $display("FAIL b2b_second_hold: hi/lo %h want 0000000100000000", {ph, pl}); end
        checks++; if ({h, l} !== e) begin errors++; $display("FAIL b2b_second_result: hi/lo %h want %h", {h, l}, e); end
        issue(2'd0, 32'hFFFF_0000, 32'h0001_0000, 64'hFFFF_FFFF_0000_0000);
        collect(0, dcyc, bcnt, ph, pl, h, l);
        e = exp_q.pop_front();
        checks++; if (dcyc != 34) begin errors++; $display("FAIL b2b_third_latency: done at cycle %0d want 34", dcyc); end
        checks++; if ({h, l} !== e) begin errors++; $display("FAIL b2b_third_result: hi/lo %h want %h", {h, l}, e); end
        @(posedge clock); #1;
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL b2b_exit: done %b busy %b want 0 0", done, busy); end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_start_while_busy();
        test_random();
        test_cancel();
        test_cancel_priority();
        test_async_reset_b2b();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter ITER, default 32, meaning the number of radix-2 iteration cycles; only 32 is supported.
REQ-002 SHALL have port clock  input  1  rising-edge clock for all state.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request from the execute stage; sampled on the rising edge of clock.
REQ-005 SHALL have port op  input  2  operation code: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL have port rs  input  32  multiplicand or dividend.
REQ-007 SHALL have port rt  input  32  multiplier or divisor.
REQ-008 SHALL have port cancel  input  1  pipeline flush; aborts an in-flight operation.
REQ-009 SHALL have port busy  output  1  high while an operation is in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse when a result is committed.
REQ-011 SHALL have port hi  output  32  architectural HI register.
REQ-012 SHALL have port lo  output  32  architectural LO register.

Function
REQ-013 SHALL implement states IDLE, CALC, FIX and DONE.
REQ-014 SHALL accept start only when busy=0 (IDLE or DONE); op, rs and rt are latched internally on the accepting edge, and later input changes have no effect on that operation.
REQ-015 SHALL ignore start while busy=1, with no queuing.
REQ-016 SHALL go from IDLE or DONE to CALC on an accepted start; from CALC to FIX after exactly 32 CALC cycles; from FIX to DONE after 1 cycle; from DONE to IDLE, or to CALC if start=1.
REQ-017 SHALL hold busy=1 in CALC and FIX only, and done=1 in DONE only.
REQ-018 SHALL have a latency where the accepting edge is cycle 0, busy=1 in cycles 1..33, and done=1 in cycle 34.
REQ-019 SHALL update hi and lo on the same edge that enters DONE, with hi and lo holding the new result in cycle 34; hi and lo are otherwise unchanged.
REQ-020 SHALL for MULTU produce {hi,lo} = zero-extended rs × zero-extended rt, as a 64-bit exact product using shift-add, one bit per CALC cycle.
REQ-021 SHALL for MULT produce {hi,lo} = the signed 64-bit two's-complement product; magnitudes are used in CALC and the sign is applied in FIX.
REQ-022 SHALL for DIVU produce lo = rs / rt (unsigned quotient) and hi = rs mod rt, using restoring division at one quotient bit per CALC cycle.
REQ-023 SHALL for DIV truncate the quotient toward zero, give the remainder the sign of the dividend, and apply the sign correction in FIX.
REQ-024 SHALL for DIV with rs=0x80000000 and rt=0xFFFFFFFF produce lo=0x80000000 and hi=0x00000000, with no trap.
REQ-025 SHALL for DIV or DIVU with rt=0 produce lo=0xFFFFFFFF and hi=latched rs, with the same 34-cycle latency.
REQ-026 SHALL on cancel=1 during CALC or FIX go to IDLE on the next edge, with busy=0, no done pulse, and hi and lo unchanged.
REQ-027 SHALL give cancel priority over start on the same edge; cancel in IDLE or DONE has no effect on hi and lo, and DONE still exits.
REQ-028 SHALL allow back-to-back operation: start in DONE re-enters CALC, and done is high only in that DONE cycle.

Reset
REQ-029 SHALL on reset=1 immediately force state=IDLE, busy=0, done=0, hi=0x00000000, lo=0x00000000 and clear all internal registers, independent of clock.
REQ-030 SHALL, when reset is asserted mid-operation, discard the operation, so that no done pulse follows reset deassertion.
REQ-031 SHALL ignore start while reset=1.

Verification
REQ-032 SHALL cover MULTU: rs=0xFFFFFFFF, rt=0xFFFFFFFF -> done in cycle 34, hi=0xFFFFFFFE, lo=0x00000001, and busy high for exactly 33 cycles.
REQ-033 SHALL cover MULT: rs=0xFFFFFFFD (-3), rt=0x00000007 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21).
REQ-034 SHALL cover DIV: rs=0xFFFFFFF9 (-7), rt=0x00000002 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); and DIVU: rs=100, rt=7 -> lo=14, hi=2.
REQ-035 SHALL cover divide by zero: DIVU with rs=0x12345678, rt=0 -> lo=0xFFFFFFFF, hi=0x12345678; and DIV with rs=0x80000000, rt=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-036 SHALL cover cancel and start while busy: start MULTU 5×6, pulse start again in cycle 10 with different operands (ignored), then cancel in cycle 20 -> busy=0 in cycle 21, no done, and hi/lo keep their prior values.
REQ-037 SHALL cover async reset and back-to-back: assert reset in cycle 15 of a DIV -> busy, done, hi and lo go to 0 before the next clock edge; after release, start in a DONE cycle -> a second done exactly 34 cycles later.
